// File: rtl/rf_writeback.sv
// rf_writeback: write-back stage for the register file's single write port.
// Results from the load unit and the ALU are accepted over valid/ready,
// queued in an in-order FIFO and retired one register write per cycle.
// Handshake: a transfer happens at a posedge where valid && ready are both
// high; ready never depends on the same cycle's pop, and load has priority.
// Pending destination registers are exposed for RAW hazard stalls in decode.
module rf_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [AW-1:0]                alu_rd,
    input  logic [DW-1:0]                alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [AW-1:0]                mem_rd,
    input  logic [DW-1:0]                mem_data,
    output logic                         RegWrite,
    output logic [AW-1:0]                rc,
    output logic [DW-1:0]                dc,
    input  logic [AW-1:0]                qa,
    input  logic [AW-1:0]                qb,
    output logic                         busy_a,
    output logic                         busy_b,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] rd_mem_q   [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          regwrite_q;
    logic [AW-1:0] rc_q;
    logic [DW-1:0] dc_q;

    logic          accept;
    logic          push;
    logic          pop;
    logic [AW-1:0] push_rd;
    logic [DW-1:0] push_data;
    logic [DEPTH-1:0] occupied;
    logic          hit_a;
    logic          hit_b;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;

    assign RegWrite  = regwrite_q;
    assign rc        = rc_q;
    assign dc        = dc_q;

    // Select the accepted result; load wins whenever it is offered.
    always_comb begin
        accept    = 1'b0;
        push_rd   = alu_rd;
        push_data = alu_data;
        if (mem_valid && mem_ready) begin
            accept    = 1'b1;
            push_rd   = mem_rd;
            push_data = mem_data;
        end else if (alu_valid && alu_ready) begin
            accept    = 1'b1;
        end
    end

    // Writes to $0 are consumed without occupying a slot.
    assign push = accept && (push_rd != '0);
    assign pop  = !empty;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Mark entries between the read pointer and read pointer + count as live.
    always_comb begin
        logic [PW-1:0] offset;
        offset   = '0;
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset      = PW'(i) - rd_ptr_q;
            occupied[i] = (CW'(offset) < count_q);
        end
    end

    // Match read addresses against live entries and the write in flight.
    always_comb begin
        hit_a = regwrite_q && (rc_q == qa);
        hit_b = regwrite_q && (rc_q == qb);
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && (rd_mem_q[i] == qa)) hit_a = 1'b1;
            if (occupied[i] && (rd_mem_q[i] == qb)) hit_b = 1'b1;
        end
    end

    assign busy_a = (qa != '0) && hit_a;
    assign busy_b = (qb != '0) && hit_b;

    // FIFO storage; contents are only meaningful while occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= push_rd;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers, occupancy and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            rc_q       <= '0;
            dc_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            regwrite_q <= pop;
            if (pop) begin
                rc_q <= rd_mem_q[rd_ptr_q];
                dc_q <= data_mem_q[rd_ptr_q];
            end
        end
    end

endmodule
